// File: rtl/latch_ctrl_pkg.sv
// Shared types and sizing helpers for the latch bank sequencer and its arbiter.
package latch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Timer only ever holds duration-1, so clog2(max) bits suffice (at least one).
    function automatic int unsigned timer_width(input int unsigned s,
                                                input int unsigned p,
                                                input int unsigned h);
        int unsigned m;
        m = (s > p) ? s : p;
        m = (m > h) ? m : h;
        return (clog2(m) == 0) ? 1 : clog2(m);
    endfunction

    localparam int unsigned DEF_SETUP_CYC = 1;
    localparam int unsigned DEF_PULSE_CYC = 2;
    localparam int unsigned DEF_HOLD_CYC  = 1;
    localparam int unsigned TIMER_W = timer_width(DEF_SETUP_CYC, DEF_PULSE_CYC, DEF_HOLD_CYC);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping upward.
module rr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] idx_c,
    output logic          valid_c
);

    int unsigned j;

    // Scan from farthest to nearest so the closest requester to ptr wins last.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        j       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (32'(ptr) + 32'(k)) % N;
            if (req[j]) begin
                grant_c    = '0;
                grant_c[j] = 1'b1;
                idx_c      = IW'(j);
                valid_c    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/latch_bank_sequencer.sv
// Arbitrates requester writes into a shared D-latch bank with setup/pulse/hold sequencing.
// Optional readback check enabled by defining LATCH_VERIFY_EN.
module latch_bank_sequencer
    import latch_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_LATCH = 8,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned AW        = 3,
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*AW-1:0]      req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic [WIDTH-1:0]           latch_d,
    output logic [NUM_LATCH-1:0]       latch_c,
    input  logic [NUM_LATCH*WIDTH-1:0] rd_q,
    output logic                       err_addr,
    output logic                       err_verify
);

    localparam int unsigned TW = timer_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int unsigned IW = clog2(NUM_REQ);
    localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);

    state_t               state, state_n;
    logic [TW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        ptr, ptr_n;
    logic [AW-1:0]        cap_addr, addr_n;
    logic [NUM_REQ-1:0]   cap_grant, grant_n;
    logic [WIDTH-1:0]     d_n;
    logic [NUM_LATCH-1:0] c_n;
    logic [NUM_REQ-1:0]   ack_n;
    logic                 busy_n, err_addr_n, err_verify_n;
    logic                 in_range, last_hold, verify_bad;

    logic [NUM_REQ-1:0]   win_grant;
    logic [IW-1:0]        win_idx;
    logic                 win_valid;
    logic [AW-1:0]        win_addr;
    logic [WIDTH-1:0]     win_data;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .grant_c (win_grant),
        .idx_c   (win_idx),
        .valid_c (win_valid)
    );

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef LATCH_VERIFY_EN
    logic [WIDTH-1:0] rd_word;

    // latch_d still carries the written word throughout HOLD.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_LATCH; i++) begin
            if (cap_addr == AW'(i)) rd_word = rd_q[i*WIDTH +: WIDTH];
        end
    end
    assign verify_bad = (rd_word != latch_d);
`else
    logic unused_rd_q;
    assign unused_rd_q = ^rd_q;
    assign verify_bad  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '0;
            cap_addr   <= '0;
            cap_grant  <= '0;
            latch_d    <= '0;
            latch_c    <= '0;
            ack        <= '0;
            busy       <= 1'b0;
            err_addr   <= 1'b0;
            err_verify <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            cap_addr   <= addr_n;
            cap_grant  <= grant_n;
            latch_d    <= d_n;
            latch_c    <= c_n;
            ack        <= ack_n;
            busy       <= busy_n;
            err_addr   <= err_addr_n;
            err_verify <= err_verify_n;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        ptr_n        = ptr;
        addr_n       = cap_addr;
        grant_n      = cap_grant;
        d_n          = latch_d;
        c_n          = '0;
        ack_n        = '0;
        err_addr_n   = 1'b0;
        err_verify_n = 1'b0;

        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_n = SETUP;
                    cnt_n   = SETUP_LD;
                    ptr_n   = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IW'(1);
                    addr_n  = win_addr;
                    grant_n = win_grant;
                    d_n     = win_data;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = ENABLE;
                    cnt_n   = PULSE_LD;
                end else begin
                    cnt_n = cnt - TW'(1);
                end
            end
            ENABLE: begin
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LD;
                end else begin
                    cnt_n = cnt - TW'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        in_range  = (32'(addr_n) < NUM_LATCH);
        last_hold = (state_n == HOLD) && (cnt_n == '0);
        busy_n    = (state_n != IDLE);

        if (state_n == ENABLE && in_range) begin
            for (int unsigned i = 0; i < NUM_LATCH; i++) begin
                if (addr_n == AW'(i)) c_n[i] = 1'b1;
            end
        end

        if (last_hold) begin
            ack_n        = grant_n;
            err_addr_n   = !in_range;
            err_verify_n = in_range && verify_bad;
        end
    end

    // D may only move while every enable is low, both before and after the edge.
    a_d_stable: assert property (@(posedge clk) disable iff (rst)
        !$stable(latch_d) |-> (latch_c == '0) && (($past(latch_c) == '0) || $past(rst)));

    a_c_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(latch_c));

endmodule
